// File: rtl/l2_pkg.sv
// Shared record definitions: transform modes and the width-generic {a,b} transform helper.
package l2_pkg;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        SWAP = 2'd1,
        SUM  = 2'd2,
        CLR  = 2'd3
    } rec_mode_e;

    localparam int AB_DEF_W    = 8;
    localparam int AB_XF_MAX_W = 32;

    // Inputs are zero-extended to AB_XF_MAX_W; w is the real field width (<= AB_XF_MAX_W).
    // Result is {a', b'}, each in an AB_XF_MAX_W slot with only the low w bits meaningful.
    function automatic logic [2*AB_XF_MAX_W-1:0] ab_xform(
        input rec_mode_e                mode,
        input logic [AB_XF_MAX_W-1:0]   a,
        input logic [AB_XF_MAX_W-1:0]   b,
        input int unsigned              w
    );
        logic [AB_XF_MAX_W:0]   sum;
        logic [AB_XF_MAX_W:0]   sum_sh;
        logic [AB_XF_MAX_W-1:0] mask;
        logic [AB_XF_MAX_W-1:0] res_a;
        logic [AB_XF_MAX_W-1:0] res_b;
        sum    = {1'b0, a} + {1'b0, b};
        sum_sh = sum >> w;
        mask   = (w >= AB_XF_MAX_W) ? '1 : ((AB_XF_MAX_W'(1) << w) - AB_XF_MAX_W'(1));
        res_a  = '0;
        res_b  = '0;
        case (mode)
            PASS: begin res_a = a; res_b = b; end
            SWAP: begin res_a = b; res_b = a; end
            SUM: begin
                res_a = sum[AB_XF_MAX_W-1:0] & mask;
                res_b = {{(AB_XF_MAX_W-1){1'b0}}, sum_sh[0]};
            end
            default: begin res_a = '0; res_b = '0; end
        endcase
        return {res_a, res_b};
    endfunction

endpackage

// File: rtl/ab_fifo_mem.sv
// Record storage with one write port and a registered head-of-queue read.
// The head register loads either the incoming write data (empty-queue refill) or a stored entry.
module ab_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_ld,
    input  logic                     i_byp,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset; only the visible head is cleared.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_rdata <= '0;
        else if (i_ld)
            o_rdata <= i_byp ? i_wdata : r_mem[i_raddr];
    end

endmodule

// File: rtl/ab_record_fifo.sv
// FWFT record FIFO with write-time {a,b} transform; head appears the cycle after a push.
// Optional occupancy/stall statistics ports enabled by AB_FIFO_STATS_EN.
module ab_record_fifo
    import l2_pkg::*;
#(
    parameter int FIELD_W = 8,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FIELD_W-1:0]         in_a,
    input  logic [FIELD_W-1:0]         in_b,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIELD_W-1:0]         out_a,
    output logic [FIELD_W-1:0]         out_b,
    output logic [2*FIELD_W-1:0]       out_word,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
`ifdef AB_FIFO_STATS_EN
    ,
    output logic [15:0]                stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

    localparam int W  = 2 * FIELD_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [FIELD_W-1:0] a;
        logic [FIELD_W-1:0] b;
    } rec_t;

    typedef union packed {
        rec_t         rec;
        logic [W-1:0] word;
    } rec_u;

    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     r_full;
    logic                     r_empty;
    logic                     r_vld;
    logic [CW-1:0]            w_count_nxt;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_byp;
    logic                     w_ld;
    logic [2*AB_XF_MAX_W-1:0] w_xf;
    logic                     w_unused_xf;
    rec_t                     w_wrec;
    logic [W-1:0]             w_rdata;
    rec_u                     w_head;

    assign in_ready = !r_full && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = r_vld && out_ready;

    assign w_xf        = ab_xform(rec_mode_e'(mode), AB_XF_MAX_W'(in_a), AB_XF_MAX_W'(in_b), FIELD_W);
    assign w_wrec.a    = w_xf[AB_XF_MAX_W +: FIELD_W];
    assign w_wrec.b    = w_xf[0 +: FIELD_W];
    assign w_unused_xf = ^w_xf;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // The pushed record becomes the head directly when nothing older will remain queued.
    assign w_byp = w_push && (r_empty || (w_pop && r_count == CW'(1)));
    assign w_ld  = w_byp || (w_pop && r_count > CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_vld    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_vld   <= (w_count_nxt != '0);
        end
    end

    ab_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wrec),
        .i_ld    (w_ld),
        .i_byp   (w_byp),
        .i_raddr (r_rd_ptr + PW'(1)),
        .o_rdata (w_rdata)
    );

    assign w_head    = w_rdata;
    assign out_word  = w_head.word;
    assign out_a     = w_head.rec.a;
    assign out_b     = w_head.rec.b;
    assign out_valid = r_vld;
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;

`ifdef AB_FIFO_STATS_EN
    logic [15:0]   r_stall_cnt;
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_hwm       <= '0;
        end else begin
            if (in_valid && !in_ready && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_count_nxt > r_hwm)
                r_hwm <= w_count_nxt;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign hwm       = r_hwm;
`endif

endmodule

// File: tb/tb_ab_record_fifo.sv
// Directed plus randomized bench for ab_record_fifo against a queue-based record model.
module tb_ab_record_fifo;

    localparam int FW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_a;
    logic [FW-1:0] in_b;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_a;
    logic [FW-1:0] out_b;
    logic [2*FW-1:0] out_word;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef AB_FIFO_STATS_EN
    logic [15:0]   stall_cnt;
    logic [CW-1:0] hwm;
    int            m_stall;
    int            m_hwm;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] q[$];
    bit          m_push;
    bit          m_pop;
    bit          out_zero;

    always #5 clk = ~clk;

    ab_record_fifo #(.FIELD_W(FW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_word  (out_word),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef AB_FIFO_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .hwm       (hwm)
`endif
    );

    function automatic logic [15:0] ref_xf(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        int s;
        logic [7:0] lo;
        logic [7:0] hi;
        s  = int'(a) + int'(b);
        lo = 8'(s % 256);
        hi = 8'(s / 256);
        case (m)
            2'd0:    return {a, b};
            2'd1:    return {b, a};
            2'd2:    return {lo, hi};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_rdy;
        exp_rdy = (q.size() < DEPTH) && !rst;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (q.size() > 0) begin
            chk("out_word", 32'(out_word), 32'(q[0]));
            chk("out_a", 32'(out_a), 32'(q[0][15:8]));
            chk("out_b", 32'(out_b), 32'(q[0][7:0]));
        end else if (out_zero) begin
            chk("out_word_rst", 32'(out_word), 32'h0);
        end
`ifdef AB_FIFO_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
    endtask

    // Advance one clock: model the edge from the bench's own inputs, then check at the falling edge.
    task automatic tick();
        bit rdy;
        @(posedge clk);
        rdy    = (q.size() < DEPTH) && !rst;
        m_push = in_valid && rdy;
        m_pop  = (q.size() > 0) && out_ready;
`ifdef AB_FIFO_STATS_EN
        if (rst) begin
            m_stall = 0;
        end else if (in_valid && !rdy && m_stall < 65535) begin
            m_stall++;
        end
`endif
        if (rst) begin
            q.delete();
            out_zero = 1'b1;
            m_push   = 1'b0;
            m_pop    = 1'b0;
        end else begin
            if (m_pop)
                void'(q.pop_front());
            if (m_push) begin
                q.push_back(ref_xf(mode, in_a, in_b));
                out_zero = 1'b0;
            end
        end
`ifdef AB_FIFO_STATS_EN
        if (rst)
            m_hwm = 0;
        else if (q.size() > m_hwm)
            m_hwm = q.size();
`endif
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        mode     = m;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mode      = 2'd0;
        out_ready = 1'b0;
        out_zero  = 1'b1;
`ifdef AB_FIFO_STATS_EN
        m_stall = 0;
        m_hwm   = 0;
`endif

        // Reset held for three cycles
        repeat (3) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_empty", 32'(empty), 32'h1);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // PASS then SWAP
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 8'h01, 8'h02);
        tick();
        chk("pass_word", 32'(out_word), 32'h0102);
        drive(1'b1, 2'd1, 8'h03, 8'h04);
        tick();
        chk("swap_a", 32'(out_a), 32'h04);
        chk("swap_b", 32'(out_b), 32'h03);

        // SUM with carry, then CLR
        drive(1'b1, 2'd2, 8'hF0, 8'h20);
        tick();
        chk("sum_a", 32'(out_a), 32'h10);
        chk("sum_b", 32'(out_b), 32'h01);
        drive(1'b1, 2'd3, 8'h55, 8'hAA);
        tick();
        chk("clr_word", 32'(out_word), 32'h0000);
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        tick();

        // Fill to full, hold the ninth record, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd0, 8'(i), 8'(i));
            tick();
        end
        chk("fill_full", 32'(full), 32'h1);
        drive(1'b1, 2'd0, 8'd8, 8'd8);
        tick();
        tick();
        chk("held_in_ready", 32'(in_ready), 32'h0);
        chk("held_count", 32'(count), 32'd8);
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            if (q.size() > 0)
                chk("drain_order", 32'(out_a), 32'(k));
            tick();
            if (m_pop)
                k++;
            if (m_push)
                in_valid = 1'b0;
        end
        chk("drain_total", 32'(k), 32'd9);
        chk("drain_empty", 32'(empty), 32'h1);

        // Steady push+pop at count 4 across the pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 8'(8'h10 + i), 8'(i));
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 2'($urandom_range(0, 2)), 8'(8'h20 + j), 8'($urandom));
            tick();
            chk("steady_count", 32'(count), 32'd4);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++)
            tick();
        chk("steady_drained", 32'(empty), 32'h1);

        // Reset with five entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 8'(8'h30 + i), 8'(i));
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("mid_rst_empty", 32'(empty), 32'h1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_word", 32'(out_word), 32'h0);
`ifdef AB_FIFO_STATS_EN
        chk("mid_rst_stall", 32'(stall_cnt), 32'h0);
        chk("mid_rst_hwm", 32'(hwm), 32'h0);
`endif
        rst = 1'b0;
        drive(1'b1, 2'd0, 8'hAB, 8'hCD);
        tick();
        chk("post_rst_first", 32'(out_word), 32'hABCD);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // Randomized traffic with producer hold and occasional reset
        for (int c = 0; c < 800; c++) begin
            if (!in_valid || m_push)
                drive(1'($urandom_range(0, 9) < 7), 2'($urandom), 8'($urandom), 8'($urandom));
            out_ready = 1'($urandom_range(0, 9) < ((c / 200) % 2 == 0 ? 7 : 3));
            rst       = 1'($urandom_range(0, 199) == 0);
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++)
            tick();
        chk("final_empty", 32'(empty), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
